timer_tick_service: RTL and testbench

//  Avalon-MM master that owns the interval timer's 16-bit s1 slave port. After reset it programs the period and starts the timer in continuous, interrupt-enabled mode.
//  It services the timer irq by clearing the status register, and maintains a 32-bit tick count plus a one-cycle tick strobe for the rest of the system.
//  It also handles two user requests: reprogramming the period, and atomic 32-bit counter snapshots.

---
 rtl/timer_tick_service.sv | 162 ++++++++++++++++
 tb/tb_timer_tick_service.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_service.sv
// Avalon-MM master for the interval timer s1 port: initial programming, irq service with
// a 32-bit tick counter, period reprogramming and atomic 32-bit counter snapshots.
module timer_tick_service #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd99999,
  parameter logic [3:0]  CTRL_RUN       = 4'h7,
  parameter logic [3:0]  CTRL_STOP      = 4'h8
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq,
  input  logic [31:0] period_in,
  input  logic        reprogram_req,
  output logic        reprogram_ack,
  input  logic        snap_req,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic [31:0] tick_count,
  output logic        tick_pulse,
  output logic        busy
);

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PERL    = 3'd2;
  localparam logic [2:0] A_PERH    = 3'd3;
  localparam logic [2:0] A_SNAPL   = 3'd4;
  localparam logic [2:0] A_SNAPH   = 3'd5;

  typedef enum logic [3:0] {
    INIT_PL, INIT_PH, INIT_CTRL, IDLE,
    CLR_ST, CLR_WAIT,
    RP_STOP, RP_PL, RP_PH, RP_CTRL, RP_ACK,
    SN_WR, SN_RL, SN_RH, SN_DONE
  } state_t;

  state_t      state, state_next;
  logic        armed;
  logic [31:0] load;
  logic [31:0] snap_q;

  // armed keeps the bus idle for the first cycle spent in INIT_PL after a reset edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= INIT_PL;
      armed      <= 1'b0;
      load       <= DEFAULT_PERIOD;
      tick_count <= 32'd0;
      snap_q     <= 32'd0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
      if (state == IDLE && !tmr_irq && reprogram_req)
        load <= period_in;
      if (state == CLR_ST)
        tick_count <= tick_count + 32'd1;
      if (state == SN_RH)
        snap_q[15:0] <= tmr_readdata;
      if (state == SN_DONE)
        snap_q[31:16] <= tmr_readdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT_PL:   if (armed) state_next = INIT_PH;
      INIT_PH:   state_next = INIT_CTRL;
      INIT_CTRL: state_next = IDLE;
      IDLE: begin
        if (tmr_irq)            state_next = CLR_ST;
        else if (reprogram_req) state_next = RP_STOP;
        else if (snap_req)      state_next = SN_WR;
      end
      CLR_ST:    state_next = CLR_WAIT;
      CLR_WAIT:  state_next = IDLE;
      RP_STOP:   state_next = RP_PL;
      RP_PL:     state_next = RP_PH;
      RP_PH:     state_next = RP_CTRL;
      RP_CTRL:   state_next = RP_ACK;
      RP_ACK:    state_next = IDLE;
      SN_WR:     state_next = SN_RL;
      SN_RL:     state_next = SN_RH;
      SN_RH:     state_next = SN_DONE;
      SN_DONE:   state_next = IDLE;
      default:   state_next = INIT_PL;
    endcase
  end

  // One bus access per state; the control write always follows both period writes
  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'd0;
    case (state)
      INIT_PL: begin
        if (armed) begin
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
          tmr_address    = A_PERL;
          tmr_writedata  = load[15:0];
        end
      end
      INIT_PH, RP_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_PERH;
        tmr_writedata  = load[31:16];
      end
      RP_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_PERL;
        tmr_writedata  = load[15:0];
      end
      INIT_CTRL, RP_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_CONTROL;
        tmr_writedata  = {12'h000, CTRL_RUN};
      end
      RP_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_CONTROL;
        tmr_writedata  = {12'h000, CTRL_STOP};
      end
      CLR_ST: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_STATUS;
      end
      SN_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_SNAPL;
      end
      SN_RL: begin
        tmr_chipselect = 1'b1;
        tmr_address    = A_SNAPL;
      end
      SN_RH: begin
        tmr_chipselect = 1'b1;
        tmr_address    = A_SNAPH;
      end
      default: ;
    endcase
  end

  // In SN_DONE the high half is still on readdata, so it bypasses the register
  assign snap_value    = (state == SN_DONE) ? {tmr_readdata, snap_q[15:0]} : snap_q;
  assign snap_valid    = (state == SN_DONE);
  assign tick_pulse    = (state == CLR_WAIT);
  assign reprogram_ack = (state == RP_ACK);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_timer_tick_service.sv
// Bench for timer_tick_service: behavioural interval-timer model on the s1 port plus
// directed and randomized scenarios with immediate-assertion checks.
`timescale 1ns/1ps
module tb_timer_tick_service;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;
  logic [31:0] period_in;
  logic        reprogram_req;
  logic        reprogram_ack;
  logic        snap_req;
  logic        snap_valid;
  logic [31:0] snap_value;
  logic [31:0] tick_count;
  logic        tick_pulse;
  logic        busy;

  always #5 clk = ~clk;

  timer_tick_service dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq),
    .period_in      (period_in),
    .reprogram_req  (reprogram_req),
    .reprogram_ack  (reprogram_ack),
    .snap_req       (snap_req),
    .snap_valid     (snap_valid),
    .snap_value     (snap_value),
    .tick_count     (tick_count),
    .tick_pulse     (tick_pulse),
    .busy           (busy)
  );

  // Interval timer model: down-counter with period reload, TO flag and snapshot register
  logic [31:0] m_period = 32'd0;
  logic [31:0] m_cnt    = 32'd0;
  logic [31:0] m_snap   = 32'd0;
  logic        m_run    = 1'b0;
  logic        m_cont   = 1'b0;
  logic        m_ito    = 1'b0;
  logic        m_to     = 1'b0;
  logic [15:0] rd_q     = 16'd0;
  logic        poke_en  = 1'b0;
  logic [31:0] poke_val = 32'd0;

  assign tmr_irq      = m_to & m_ito;
  assign tmr_readdata = rd_q;

  always @(posedge clk) begin
    if (m_run) begin
      if (m_cnt == 32'd0) begin
        m_to  <= 1'b1;
        m_cnt <= m_period;
        if (!m_cont) m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 32'd1;
      end
    end
    if (poke_en) m_cnt <= poke_val;
    case (tmr_address)
      3'd0:    rd_q <= {15'd0, m_to};
      3'd1:    rd_q <= {13'd0, m_run, m_cont, m_ito};
      3'd2:    rd_q <= m_period[15:0];
      3'd3:    rd_q <= m_period[31:16];
      3'd4:    rd_q <= m_snap[15:0];
      3'd5:    rd_q <= m_snap[31:16];
      default: rd_q <= 16'd0;
    endcase
    if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: m_to <= 1'b0;
        3'd1: begin
          if (tmr_writedata[2]) m_run <= 1'b1;
          if (tmr_writedata[3]) m_run <= 1'b0;
          m_cont <= tmr_writedata[1];
          m_ito  <= tmr_writedata[0];
        end
        3'd2: begin
          m_period[15:0] <= tmr_writedata;
          m_cnt          <= {m_period[31:16], tmr_writedata};
          m_run          <= 1'b0;
        end
        3'd3: begin
          m_period[31:16] <= tmr_writedata;
          m_cnt           <= {tmr_writedata, m_period[15:0]};
          m_run           <= 1'b0;
        end
        3'd4, 3'd5: m_snap <= m_cnt;
        default: ;
      endcase
    end
  end

  int passes = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Bus transaction log and irq-to-tick latency scoreboard
  int          bus_cyc[$];
  logic        bus_wr[$];
  logic [2:0]  bus_adr[$];
  logic [15:0] bus_dat[$];
  int          cyc       = 0;
  int          rise_cyc  = -100;
  int          rises     = 0;
  logic        irq_prev  = 1'b0;
  logic        lat_en    = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (tmr_irq && !irq_prev) begin
      rise_cyc = cyc;
      rises++;
    end
    irq_prev = tmr_irq;
    if (tmr_chipselect) begin
      bus_cyc.push_back(cyc);
      bus_wr.push_back(~tmr_write_n);
      bus_adr.push_back(tmr_address);
      bus_dat.push_back(tmr_writedata);
    end
    if (lat_en && tick_pulse) check("tick_latency", 32'(cyc - rise_cyc), 32'd2);
  end

  task automatic clear_log();
    bus_cyc.delete();
    bus_wr.delete();
    bus_adr.delete();
    bus_dat.delete();
  endtask

  task automatic exp_bus(input string tag, input int i, input logic wr,
                         input logic [2:0] a, input logic [15:0] d);
    logic [31:0] obs;
    logic [31:0] expv;
    if (i < bus_adr.size()) obs = {12'd0, bus_wr[i], bus_adr[i], bus_wr[i] ? bus_dat[i] : 16'h0};
    else                    obs = 32'hDEAD_BEEF;
    expv = {12'd0, wr, a, wr ? d : 16'h0};
    check(tag, obs, expv);
  endtask

  localparam int S_BUSY = 0, S_ACK = 1, S_SV = 2, S_TP = 3, S_IRQ = 4;

  function automatic logic sig(input int s);
    case (s)
      S_BUSY:  return busy;
      S_ACK:   return reprogram_ack;
      S_SV:    return snap_valid;
      S_TP:    return tick_pulse;
      S_IRQ:   return tmr_irq;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int s, input logic lvl, input int max, input string tag);
    int n = 0;
    while (sig(s) !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    if (sig(s) !== lvl) check({tag, "_timeout"}, 32'(sig(s)), 32'(lvl));
  endtask

  task automatic do_reprogram(input logic [31:0] p, input string tag);
    clear_log();
    period_in     = p;
    reprogram_req = 1'b1;
    wait_for(S_ACK, 1'b1, 30, tag);
    reprogram_req = 1'b0;
  endtask

  task automatic check_init(input string tag);
    exp_bus({tag, "_pl"},   0, 1'b1, 3'd2, 16'h869F);
    exp_bus({tag, "_ph"},   1, 1'b1, 3'd3, 16'h0001);
    exp_bus({tag, "_ctrl"}, 2, 1'b1, 3'd1, 16'h0007);
    if (bus_cyc.size() >= 3) check({tag, "_consec"}, 32'(bus_cyc[2] - bus_cyc[0]), 32'd2);
    else                     check({tag, "_consec"}, 32'(bus_cyc.size()), 32'd3);
  endtask

  initial begin
    int c1;
    int tc0;
    int r0;
    int p;
    bit hit;

    reset_n       = 1'b0;
    period_in     = 32'd0;
    reprogram_req = 1'b0;
    snap_req      = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cs",    32'(tmr_chipselect), 32'd0);
    check("rst_wn",    32'(tmr_write_n),    32'd1);
    check("rst_adr",   32'(tmr_address),    32'd0);
    check("rst_wd",    32'(tmr_writedata),  32'd0);
    check("rst_ticks", tick_count,          32'd0);
    check("rst_snap",  snap_value,          32'd0);
    check("rst_sv",    32'(snap_valid),     32'd0);
    check("rst_tp",    32'(tick_pulse),     32'd0);
    check("rst_ack",   32'(reprogram_ack),  32'd0);

    // Init sequence after reset release
    clear_log();
    reset_n = 1'b1;
    @(negedge clk);
    wait_for(S_BUSY, 1'b0, 20, "init_idle");
    check_init("init");
    check("init_busy",   32'(busy), 32'd0);
    check("init_period", m_period,  32'd99999);

    // Reprogram to 0x0003_0004
    do_reprogram(32'h0003_0004, "rp");
    exp_bus("rp_stop", 0, 1'b1, 3'd1, 16'h0008);
    exp_bus("rp_pl",   1, 1'b1, 3'd2, 16'h0004);
    exp_bus("rp_ph",   2, 1'b1, 3'd3, 16'h0003);
    exp_bus("rp_run",  3, 1'b1, 3'd1, 16'h0007);
    @(negedge clk);
    check("rp_ack_pulse", 32'(reprogram_ack), 32'd0);
    check("rp_busy",      32'(busy),          32'd0);
    check("rp_model",     m_period,           32'h0003_0004);

    // Snapshot with the counter placed at 0x0001_2345 when the snapshot write lands
    clear_log();
    poke_val = 32'h0001_2345;
    poke_en  = 1'b1;
    snap_req = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    wait_for(S_SV, 1'b1, 20, "sn");
    snap_req = 1'b0;
    check("sn_value", snap_value, 32'h0001_2345);
    exp_bus("sn_wr", 0, 1'b1, 3'd4, 16'h0000);
    exp_bus("sn_rl", 1, 1'b0, 3'd4, 16'h0000);
    exp_bus("sn_rh", 2, 1'b0, 3'd5, 16'h0000);
    @(negedge clk);
    check("sn_valid_pulse", 32'(snap_valid), 32'd0);
    check("sn_hold",        snap_value,      32'h0001_2345);

    // Period 9: ten ticks per 100 cycles, each irq counted once, 2-cycle latency
    do_reprogram(32'd9, "p9");
    wait_for(S_TP, 1'b1, 40, "p9_first");
    check("p9_first_count", tick_count, 32'd1);
    tc0    = tick_count;
    r0     = rises;
    lat_en = 1'b1;
    repeat (100) @(negedge clk);
    lat_en = 1'b0;
    check("p9_ticks", tick_count - 32'(tc0), 32'd10);
    check("p9_rises", 32'(rises - r0),       32'd10);

    // Randomized periods: tick spacing equals period+1
    for (int k = 0; k < 3; k++) begin
      p = int'($urandom_range(12, 40));
      do_reprogram(32'(p), "rnd");
      wait_for(S_TP, 1'b1, 100, "rnd_t1");
      c1 = cyc;
      @(negedge clk);
      wait_for(S_TP, 1'b1, 100, "rnd_t2");
      check("rnd_spacing", 32'(cyc - c1), 32'(p + 1));
    end

    // irq and snap_req together: irq first, tick_count wraps to 0
    wait_for(S_BUSY, 1'b0, 20, "wr_idle");
    force dut.tick_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.tick_count;
    wait_for(S_IRQ, 1'b1, 100, "wr_irq");
    snap_req = 1'b1;
    wait_for(S_TP, 1'b1, 10, "wr_tick");
    check("wr_wrap",    tick_count,      32'd0);
    check("wr_no_snap", 32'(snap_valid), 32'd0);
    c1 = cyc;
    wait_for(S_SV, 1'b1, 20, "wr_snap");
    snap_req = 1'b0;
    check("wr_order",   32'(cyc - c1), 32'd5);
    check("wr_snapval", snap_value,    m_snap);

    // Reset during RP_PH
    wait_for(S_BUSY, 1'b0, 20, "mr_idle");
    period_in     = {16'h0002, 16'($urandom_range(100, 60000))};
    reprogram_req = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd3) hit = 1'b1;
    end
    check("mr_seen_ph", 32'(hit), 32'd1);
    reset_n       = 1'b0;
    reprogram_req = 1'b0;
    @(negedge clk);
    check("mr_cs",    32'(tmr_chipselect), 32'd0);
    check("mr_wn",    32'(tmr_write_n),    32'd1);
    check("mr_ticks", tick_count,          32'd0);
    check("mr_snap",  snap_value,          32'd0);
    check("mr_ack",   32'(reprogram_ack),  32'd0);
    clear_log();
    reset_n = 1'b1;
    @(negedge clk);
    wait_for(S_BUSY, 1'b0, 20, "mr_init_idle");
    check_init("mr_init");
    check("mr_period", m_period, 32'd99999);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
